pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline. Watches the decode-stage operand registers against the destinations held in the ID/EX and EX/MEM pipeline registers. Drives the operand-forwarding selects, the PC / IF-ID write enable, the ID/EX bubble-insert control and the IF flush. It also owns the sequencer that holds a multi-cycle multiply/divide (MDU) instruction in decode until the unit has finished.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/mdu_seq.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 74 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects and MDU sequencer states.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  // A load in EX cannot be forwarded yet, so an EX hit only counts for ALU results.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                         input logic mem_hit, input logic mem_ld);
    if (ex_hit && !ex_ld) return FWD_EXALU;
    if (mem_hit)          return mem_ld ? FWD_MEMLD : FWD_MEMALU;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Holds a multi-cycle MDU op in decode: MDU_LAT stall cycles, registered one-cycle mdu_start.
// No launch while hold (data hazard) is high; DONE always returns to IDLE without relaunching.
module mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic clrn,
  input  logic d_mdu,
  input  logic hold,
  output logic mdu_stall,
  output logic mdu_start,
  output logic mdu_busy
);

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 2);

  mdu_state_t    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          start_nxt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      count     <= '0;
      mdu_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      mdu_start <= start_nxt;
    end
  end

  // BUSY runs count = MDU_LAT-2 down to 0 inclusive, which with the IDLE cycle gives MDU_LAT stalls.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    start_nxt = 1'b0;
    case (state)
      IDLE: if (d_mdu && !hold) begin
        state_nxt = BUSY;
        count_nxt = CNT_INIT;
        start_nxt = 1'b1;
      end
      BUSY: begin
        if (count == '0) state_nxt = DONE;
        else             count_nxt = count - CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mdu_stall = ((state == IDLE) && d_mdu) || (state == BUSY);
  assign mdu_busy  = (state != IDLE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard control: forwarding selects, load-use / MDU stalls, IF flush.
// Combinational controls, no added latency; PIPE_FWD_EN enables forwarding, else any RAW hit stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             d_mdu,
  input  logic             d_branch,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  output logic             wpcir,
  output logic             dbubble,
  output logic             ifflush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic data_stall, mdu_stall, stall;

  assign ex_rs  = ewreg && (ern != 5'd0) && (ern == rs);
  assign ex_rt  = ewreg && (ern != 5'd0) && (ern == rt);
  assign mem_rs = mwreg && (mrn != 5'd0) && (mrn == rs);
  assign mem_rt = mwreg && (mrn != 5'd0) && (mrn == rt);

`ifdef PIPE_FWD_EN
  assign fwda       = fwd_sel(ex_rs, em2reg, mem_rs, mm2reg);
  assign fwdb       = fwd_sel(ex_rt, em2reg, mem_rt, mm2reg);
  assign data_stall = em2reg && ((use_rs && ex_rs) || (use_rt && ex_rt));
`else
  logic unused_ld;
  assign unused_ld  = em2reg ^ mm2reg;
  assign fwda       = FWD_RF;
  assign fwdb       = FWD_RF;
  assign data_stall = (use_rs && (ex_rs || mem_rs)) || (use_rt && (ex_rt || mem_rt));
`endif

  mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
    .clk       (clk),
    .clrn      (clrn),
    .d_mdu     (d_mdu),
    .hold      (data_stall),
    .mdu_stall (mdu_stall),
    .mdu_start (mdu_start),
    .mdu_busy  (mdu_busy)
  );

  assign stall   = data_stall || mdu_stall;
  assign wpcir   = !stall;
  assign dbubble = stall;
  // A stalled branch may be using stale operands; it resolves again once released.
  assign ifflush = d_branch && !stall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                         stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a scoreboard queue of expected per-cycle outputs.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 3;
`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic clrn;
  logic [4:0] rs, rt, ern, mrn;
  logic use_rs, use_rt, d_mdu, d_branch, ewreg, em2reg, mwreg, mm2reg;
  logic wpcir, dbubble, ifflush, mdu_start, mdu_busy;
  logic [1:0] fwda, fwdb;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct packed {
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             wpcir;
    logic             dbubble;
    logic             ifflush;
    logic             mdu_start;
    logic             mdu_busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  logic [CNT_W-1:0] sc_model;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .d_mdu(d_mdu), .d_branch(d_branch), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
    .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .wpcir(wpcir), .dbubble(dbubble),
    .ifflush(ifflush), .fwda(fwda), .fwdb(fwdb), .mdu_start(mdu_start),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  task automatic clr_in();
    rs = 0; rt = 0; ern = 0; mrn = 0;
    use_rs = 0; use_rt = 0; d_mdu = 0; d_branch = 0;
    ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0h expected %0h at %0t", tag, fld, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] efa, input logic [1:0] efb, input logic est,
                          input logic eif, input logic estart, input logic ebusy);
    exp_t e;
    e.fwda = efa; e.fwdb = efb; e.wpcir = !est; e.dbubble = est; e.ifflush = eif;
    e.mdu_start = estart; e.mdu_busy = ebusy; e.cnt = sc_model;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    e = q.pop_front();
    cmp(tag, "fwda", 16'(fwda), 16'(e.fwda));
    cmp(tag, "fwdb", 16'(fwdb), 16'(e.fwdb));
    cmp(tag, "wpcir", 16'(wpcir), 16'(e.wpcir));
    cmp(tag, "dbubble", 16'(dbubble), 16'(e.dbubble));
    cmp(tag, "ifflush", 16'(ifflush), 16'(e.ifflush));
    cmp(tag, "mdu_start", 16'(mdu_start), 16'(e.mdu_start));
    cmp(tag, "mdu_busy", 16'(mdu_busy), 16'(e.mdu_busy));
    cmp(tag, "stall_cnt", 16'(stall_cnt), 16'(e.cnt));
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cyc(input string tag, input logic [1:0] efa, input logic [1:0] efb, input logic est,
                     input logic eif, input logic estart, input logic ebusy);
    push_exp(efa, efb, est, eif, estart, ebusy);
    @(negedge clk);
    pop_cmp(tag);
    @(posedge clk);
    if (est && (sc_model != '1)) sc_model = sc_model + 1'b1;
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    clr_in();
    sc_model = '0;
    #1;
    push_exp(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_cmp("reset");
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;

    clr_in(); ewreg = 1; ern = 5; rs = 5; use_rs = 1;
    cyc("ex_alu_fwd", FWD ? 2'd1 : 2'd0, 2'd0, !FWD, 0, 0, 0);
    ern = 0; rs = 0;
    cyc("r0_no_match", 2'd0, 2'd0, 0, 0, 0, 0);

    clr_in(); ewreg = 1; em2reg = 1; ern = 8; rt = 8; use_rt = 1;
    cyc("load_use", 2'd0, 2'd0, 1, 0, 0, 0);
    clr_in(); mwreg = 1; mm2reg = 1; mrn = 8; rt = 8; use_rt = 1;
    cyc("mem_ld_fwd", 2'd0, FWD ? 2'd3 : 2'd0, !FWD, 0, 0, 0);

    clr_in(); ewreg = 1; ern = 7; mwreg = 1; mrn = 7; rs = 7; rt = 7; use_rs = 1; use_rt = 1;
    cyc("ex_priority", FWD ? 2'd1 : 2'd0, FWD ? 2'd1 : 2'd0, !FWD, 0, 0, 0);
    clr_in(); mwreg = 1; mrn = 3; rs = 3; use_rs = 1;
    cyc("mem_alu", FWD ? 2'd2 : 2'd0, 2'd0, !FWD, 0, 0, 0);
    clr_in(); ewreg = 1; em2reg = 1; ern = 4; rs = 4;
    cyc("load_not_used", 2'd0, 2'd0, 0, 0, 0, 0);
    clr_in(); mwreg = 1; use_rs = 1; use_rt = 1;
    cyc("mem_r0", 2'd0, 2'd0, 0, 0, 0, 0);

    clr_in(); ewreg = 1; em2reg = 1; ern = 8; rt = 8; use_rt = 1; d_branch = 1;
    cyc("branch_in_stall", 2'd0, 2'd0, 1, 0, 0, 0);
    clr_in(); d_branch = 1;
    cyc("branch_flush", 2'd0, 2'd0, 0, 1, 0, 0);

    clr_in(); d_mdu = 1;
    cyc("mdu_idle", 2'd0, 2'd0, 1, 0, 0, 0);
    cyc("mdu_busy_a", 2'd0, 2'd0, 1, 0, 1, 1);
    cyc("mdu_busy_b", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("mdu_busy_c", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("mdu_done", 2'd0, 2'd0, 0, 0, 0, 1);
    d_mdu = 0;
    cyc("mdu_after_a", 2'd0, 2'd0, 0, 0, 0, 0);
    cyc("mdu_after_b", 2'd0, 2'd0, 0, 0, 0, 0);

    clr_in(); ewreg = 1; em2reg = 1; ern = 8; rt = 8; use_rt = 1; d_mdu = 1;
    cyc("lu_mdu_hold", 2'd0, 2'd0, 1, 0, 0, 0);
    clr_in(); d_mdu = 1;
    cyc("lu_mdu_launch", 2'd0, 2'd0, 1, 0, 0, 0);
    cyc("lu_mdu_start", 2'd0, 2'd0, 1, 0, 1, 1);
    cyc("lu_mdu_busy_b", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("lu_mdu_busy_c", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("lu_mdu_done", 2'd0, 2'd0, 0, 0, 0, 1);
    d_mdu = 0;
    cyc("lu_mdu_after", 2'd0, 2'd0, 0, 0, 0, 0);

    clr_in(); d_mdu = 1;
    cyc("rst_seq_idle", 2'd0, 2'd0, 1, 0, 0, 0);
    cyc("rst_seq_busy", 2'd0, 2'd0, 1, 0, 1, 1);
    clrn = 1'b0; d_mdu = 0; sc_model = '0;
    push_exp(2'd0, 2'd0, 0, 0, 0, 0);
    #1;
    pop_cmp("async_reset_busy");
    #1 clrn = 1'b1;
    cyc("post_rst_quiet", 2'd0, 2'd0, 0, 0, 0, 0);
    d_mdu = 1;
    cyc("post_rst_idle", 2'd0, 2'd0, 1, 0, 0, 0);
    cyc("post_rst_start", 2'd0, 2'd0, 1, 0, 1, 1);
    cyc("post_rst_busy_b", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("post_rst_busy_c", 2'd0, 2'd0, 1, 0, 0, 1);
    cyc("post_rst_done", 2'd0, 2'd0, 0, 0, 0, 1);
    d_mdu = 0;
    cyc("post_rst_after", 2'd0, 2'd0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
